reg_wr_en_sequencer: RTL and testbench



---
 rtl/reg_wr_en_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_reg_wr_en_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_en_sequencer.sv
// Registered one-hot write-enable sequencer: latches a select code on load, drives a pulsed or held enable.
// Latency: a load accepted at edge t drives en from t+1; back-to-back pulse requests issue with no gap.
// Backpressure: none; a one-deep pending slot absorbs a follow-on pulse request, and a further one is dropped and flagged as overrun.
module reg_wr_en_sequencer #(
    parameter int SEL_W     = 2,
    parameter int NUM_OUT   = 4,
    parameter int NOP_CODE  = 3,
    parameter int PULSE_LEN = 1,
    parameter int MODE      = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SEL_W-1:0]   D,
    input  logic               load,
    input  logic               clear,
    output logic [NUM_OUT-1:0] en,
    output logic               busy,
    output logic               nop_pulse,
    output logic               illegal,
    output logic               overrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Counter reload value: counts down to zero, zero marks the final pulse cycle.
    localparam logic [7:0] CNT_INIT = 8'(PULSE_LEN - 1);

    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] en_q, en_d;
    logic [NUM_OUT-1:0] pend_en_q, pend_en_d;
    logic               pend_vld_q, pend_vld_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               nop_q, nop_d;
    logic               illegal_q, illegal_d;
    logic               overrun_q, overrun_d;

    logic               code_nop;
    logic               code_in_range;
    logic               ld_legal;
    logic               ld_nop;
    logic               ld_illegal;
    logic               last_cycle;
    logic [NUM_OUT-1:0] dec_en;

    // Classify the incoming request; NOP takes precedence over the range check.
    always_comb begin
        code_nop      = (int'(D) == NOP_CODE);
        code_in_range = (int'(D) < NUM_OUT);
        ld_nop        = load && code_nop;
        ld_legal      = load && !code_nop && code_in_range;
        ld_illegal    = load && !code_nop && !code_in_range;
        last_cycle    = (cnt_q == 8'd0);
    end

    // MSB-first decode: code k drives enable bit NUM_OUT-1-k.
    always_comb begin
        dec_en = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (int'(D) == NUM_OUT - 1 - i) begin
                dec_en[i] = 1'b1;
            end
        end
    end

    // Next-state logic: clear aborts everything; otherwise pulse or hold sequencing.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        pend_en_d  = pend_en_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        nop_d      = 1'b0;
        illegal_d  = illegal_q;
        overrun_d  = overrun_q;

        if (clear) begin
            state_d    = IDLE;
            en_d       = '0;
            pend_en_d  = '0;
            pend_vld_d = 1'b0;
            cnt_d      = '0;
            illegal_d  = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            if (ld_nop) begin
                nop_d = 1'b1;
            end
            if (ld_illegal) begin
                illegal_d = 1'b1;
            end

            if (MODE != 0) begin
                // Hold mode: the latest legal code simply replaces the enable.
                if (ld_legal) begin
                    en_d    = dec_en;
                    state_d = ACTIVE;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ld_legal) begin
                            en_d    = dec_en;
                            cnt_d   = CNT_INIT;
                            state_d = ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (last_cycle) begin
                            if (pend_vld_q) begin
                                // Pending entry issues gaplessly; a new load refills the slot.
                                en_d       = pend_en_q;
                                cnt_d      = CNT_INIT;
                                pend_vld_d = ld_legal;
                                pend_en_d  = ld_legal ? dec_en : '0;
                            end else if (ld_legal) begin
                                en_d  = dec_en;
                                cnt_d = CNT_INIT;
                            end else begin
                                en_d    = '0;
                                state_d = IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                            if (ld_legal) begin
                                if (!pend_vld_q) begin
                                    pend_vld_d = 1'b1;
                                    pend_en_d  = dec_en;
                                end else begin
                                    overrun_d = 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        en_d    = '0;
                    end
                endcase
            end
        end

        busy_d = (en_d != '0) || pend_vld_d;
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            en_q       <= '0;
            pend_en_q  <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            nop_q      <= 1'b0;
            illegal_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            pend_en_q  <= pend_en_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            nop_q      <= nop_d;
            illegal_q  <= illegal_d;
            overrun_q  <= overrun_d;
        end
    end

    assign en        = en_q;
    assign busy      = busy_q;
    assign nop_pulse = nop_q;
    assign illegal   = illegal_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_reg_wr_en_sequencer.sv
// Directed bench for reg_wr_en_sequencer across five parameter sets sharing one clock and reset.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: exercises pending-slot refill, overrun drop and clear/reset aborts.
module tb_reg_wr_en_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance a: defaults (pulse mode, PULSE_LEN=1)
    logic [1:0] a_d = '0;
    logic       a_ld = 1'b0, a_clr = 1'b0;
    logic [3:0] a_en;
    logic       a_busy, a_nop, a_ill, a_ovr;
    // Instance b: PULSE_LEN=3
    logic [1:0] b_d = '0;
    logic       b_ld = 1'b0, b_clr = 1'b0;
    logic [3:0] b_en;
    logic       b_busy, b_nop, b_ill, b_ovr;
    // Instance c: PULSE_LEN=4
    logic [1:0] c_d = '0;
    logic       c_ld = 1'b0, c_clr = 1'b0;
    logic [3:0] c_en;
    logic       c_busy, c_nop, c_ill, c_ovr;
    // Instance n: NUM_OUT=3, NOP_CODE=0
    logic [1:0] n_d = '0;
    logic       n_ld = 1'b0, n_clr = 1'b0;
    logic [2:0] n_en;
    logic       n_busy, n_nop, n_ill, n_ovr;
    // Instance h: hold mode
    logic [1:0] h_d = '0;
    logic       h_ld = 1'b0, h_clr = 1'b0;
    logic [3:0] h_en;
    logic       h_busy, h_nop, h_ill, h_ovr;

    reg_wr_en_sequencer u_a (
        .clk(clk), .reset(rst), .D(a_d), .load(a_ld), .clear(a_clr),
        .en(a_en), .busy(a_busy), .nop_pulse(a_nop), .illegal(a_ill), .overrun(a_ovr)
    );
    reg_wr_en_sequencer #(.PULSE_LEN(3)) u_b (
        .clk(clk), .reset(rst), .D(b_d), .load(b_ld), .clear(b_clr),
        .en(b_en), .busy(b_busy), .nop_pulse(b_nop), .illegal(b_ill), .overrun(b_ovr)
    );
    reg_wr_en_sequencer #(.PULSE_LEN(4)) u_c (
        .clk(clk), .reset(rst), .D(c_d), .load(c_ld), .clear(c_clr),
        .en(c_en), .busy(c_busy), .nop_pulse(c_nop), .illegal(c_ill), .overrun(c_ovr)
    );
    reg_wr_en_sequencer #(.NUM_OUT(3), .NOP_CODE(0)) u_n (
        .clk(clk), .reset(rst), .D(n_d), .load(n_ld), .clear(n_clr),
        .en(n_en), .busy(n_busy), .nop_pulse(n_nop), .illegal(n_ill), .overrun(n_ovr)
    );
    reg_wr_en_sequencer #(.MODE(1)) u_h (
        .clk(clk), .reset(rst), .D(h_d), .load(h_ld), .clear(h_clr),
        .en(h_en), .busy(h_busy), .nop_pulse(h_nop), .illegal(h_ill), .overrun(h_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_a_en", a_en, 4'b0000);
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_a_nop", a_nop, 1'b0);
        chk("rst_a_ill", a_ill, 1'b0);
        chk("rst_a_ovr", a_ovr, 1'b0);
        chk("rst_c_en", c_en, 4'b0000);
        chk("rst_h_en", h_en, 4'b0000);
        rst = 1'b0;
        repeat (3) tick();

        // Single one-cycle pulse, D=01
        a_ld = 1'b1; a_d = 2'd1;
        tick();
        a_ld = 1'b0;
        chk("p1_en", a_en, 4'b0100);
        chk("p1_busy", a_busy, 1'b1);
        tick();
        chk("p1_en_off", a_en, 4'b0000);
        chk("p1_busy_off", a_busy, 1'b0);
        tick();
        chk("p1_en_off2", a_en, 4'b0000);

        // PULSE_LEN=3 back-to-back: 1000 x3 then 0010 x3
        b_ld = 1'b1; b_d = 2'd0;
        tick();
        b_d = 2'd2;
        chk("b2b_c1", b_en, 4'b1000);
        tick();
        b_ld = 1'b0;
        chk("b2b_c2", b_en, 4'b1000);
        chk("b2b_c2_busy", b_busy, 1'b1);
        tick();
        chk("b2b_c3", b_en, 4'b1000);
        tick();
        chk("b2b_c4", b_en, 4'b0010);
        tick();
        chk("b2b_c5", b_en, 4'b0010);
        tick();
        chk("b2b_c6", b_en, 4'b0010);
        tick();
        chk("b2b_c7", b_en, 4'b0000);
        chk("b2b_c7_busy", b_busy, 1'b0);
        chk("b2b_ovr", b_ovr, 1'b0);

        // PULSE_LEN=4 with three consecutive loads: third one overruns
        c_ld = 1'b1; c_d = 2'd0;
        tick();
        c_d = 2'd1;
        tick();
        c_d = 2'd2;
        chk("ovr_c2_clear", c_ovr, 1'b0);
        tick();
        c_ld = 1'b0;
        chk("ovr_c3_set", c_ovr, 1'b1);
        chk("ovr_c3_en", c_en, 4'b1000);
        tick();
        chk("ovr_c4_en", c_en, 4'b1000);
        tick();
        chk("ovr_c5_en", c_en, 4'b0100);
        repeat (3) tick();
        chk("ovr_c8_en", c_en, 4'b0100);
        tick();
        chk("ovr_c9_en", c_en, 4'b0000);
        chk("ovr_c9_busy", c_busy, 1'b0);
        tick();
        chk("ovr_c10_en", c_en, 4'b0000);
        chk("ovr_sticky", c_ovr, 1'b1);
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        chk("ovr_cleared", c_ovr, 1'b0);

        // NOP on defaults
        a_ld = 1'b1; a_d = 2'd3;
        tick();
        a_ld = 1'b0;
        chk("nop_pulse", a_nop, 1'b1);
        chk("nop_en", a_en, 4'b0000);
        chk("nop_busy", a_busy, 1'b0);
        chk("nop_not_ill", a_ill, 1'b0);
        tick();
        chk("nop_pulse_end", a_nop, 1'b0);

        // NUM_OUT=3, NOP_CODE=0: code 3 illegal, codes 1/2 legal, code 0 NOP
        n_ld = 1'b1; n_d = 2'd3;
        tick();
        n_ld = 1'b0;
        chk("ill_set", n_ill, 1'b1);
        chk("ill_en", n_en, 3'b000);
        chk("ill_no_nop", n_nop, 1'b0);
        tick();
        tick();
        chk("ill_sticky", n_ill, 1'b1);
        n_ld = 1'b1; n_d = 2'd1;
        tick();
        n_ld = 1'b0;
        chk("n3_code1", n_en, 3'b010);
        n_ld = 1'b1; n_d = 2'd2;
        tick();
        chk("n3_code2", n_en, 3'b001);
        n_d = 2'd0;
        tick();
        n_ld = 1'b0;
        chk("n3_nop", n_nop, 1'b1);
        chk("n3_nop_en", n_en, 3'b000);
        n_clr = 1'b1;
        tick();
        n_clr = 1'b0;
        chk("ill_cleared", n_ill, 1'b0);

        // Hold mode
        h_ld = 1'b1; h_d = 2'd0;
        tick();
        h_ld = 1'b0;
        chk("hold_set", h_en, 4'b1000);
        repeat (9) tick();
        chk("hold_10cyc", h_en, 4'b1000);
        chk("hold_busy", h_busy, 1'b1);
        h_ld = 1'b1; h_d = 2'd2;
        tick();
        chk("hold_replace", h_en, 4'b0010);
        tick();
        h_ld = 1'b0;
        chk("hold_same", h_en, 4'b0010);
        chk("hold_no_ovr", h_ovr, 1'b0);
        h_clr = 1'b1; h_ld = 1'b1; h_d = 2'd1;
        tick();
        h_clr = 1'b0; h_ld = 1'b0;
        chk("hold_clear", h_en, 4'b0000);
        chk("hold_clear_busy", h_busy, 1'b0);
        tick();
        chk("hold_load_ignored", h_en, 4'b0000);

        // Reset with a pending entry in the 2nd pulse cycle
        c_ld = 1'b1; c_d = 2'd0;
        tick();
        c_d = 2'd1;
        tick();
        c_ld = 1'b0;
        chk("rp_en", c_en, 4'b1000);
        chk("rp_busy", c_busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rp_en_rst", c_en, 4'b0000);
        chk("rp_busy_rst", c_busy, 1'b0);
        chk("rp_ovr_rst", c_ovr, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rp_no_issue", c_en, 4'b0000);
        end
        chk("rp_busy_end", c_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
